// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Fetch entries pair PC+4 with the fetched word, as IF/ID consumes them.
package if_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]             IF_NOP_INSTR = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_SKID = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc4;
        logic [31:0]             instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: ID control in, imem req/rvalid handshake, IF/ID write data out.
// The fetch unit is the master; memory, hazard unit and IF/ID sit on the slave side.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [31:0]       imem_rdata_i;
    logic [ADDR_W-1:0] if_pc4_o;
    logic [31:0]       if_instr_o;
    logic              if_valid_o;
    logic              if_flush_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, if_pc4_o, if_instr_o, if_valid_o, if_flush_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, if_pc4_o, if_instr_o, if_valid_o, if_flush_o
    );
endinterface

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Purpose: one output entry feeding IF/ID plus one skid entry for a response caught under stall.
// Latency: load/skid_pop become visible on the output the cycle after the edge.
// Backpressure: consume only retires the output entry; clear drops both entries at once.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear,
    input  logic         load,
    input  logic         skid_load,
    input  logic         skid_pop,
    input  logic         consume,
    input  fetch_entry_t in_dat,
    output fetch_entry_t out_dat,
    output logic         out_vld
);

    fetch_entry_t skid_dat;
    logic         skid_vld;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_dat  <= '{pc4: '0, instr: NOP_INSTR};
            out_vld  <= 1'b0;
            skid_dat <= '{pc4: '0, instr: NOP_INSTR};
            skid_vld <= 1'b0;
        end else begin
            // Redirect wins over every capture: wrong-path data never becomes valid.
            if (clear) begin
                out_vld  <= 1'b0;
                skid_vld <= 1'b0;
            end else if (load) begin
                out_dat <= in_dat;
                out_vld <= 1'b1;
            end else if (skid_pop && skid_vld) begin
                out_dat  <= skid_dat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (consume) begin
                out_vld <= 1'b0;
            end

            if (!clear && skid_load) begin
                skid_dat <= in_dat;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose: owns the PC, issues one-outstanding imem fetches, feeds IF/ID and discards wrong-path work.
// Latency: response to if_valid_o 1 cycle; redirect to first correct-path valid 2 cycles at zero mem latency.
// Backpressure: stall_i holds the output; one response lands in the skid and requests pause until it drains.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W    = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0]       NOP_INSTR = IF_NOP_INSTR
) (
    input logic             clk_i,
    input logic             rst_i,
    if_fetch_unit_if.master bus
);

    localparam logic [1:0] S_BOOT = ST_BOOT;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_SKID = ST_SKID;
    localparam logic [1:0] S_DROP = ST_DROP;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, redirect_tgt, drop_addr_q;
    logic              buf_clear, buf_load, skid_load, skid_pop, consume;
    logic              rsp_vld, redirect, stall;
    fetch_entry_t      rsp_entry, buf_entry;
    logic              buf_vld;
    logic              unused_pc_lsb;

    assign rsp_vld       = bus.imem_rvalid_i;
    assign redirect      = bus.redirect_i;
    assign stall         = bus.stall_i;
    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign redirect_tgt  = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign unused_pc_lsb = ^bus.redirect_pc_i[1:0];
    assign consume       = buf_vld & ~stall;
    assign rsp_entry     = '{pc4: pc_plus4, instr: bus.imem_rdata_i};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        skid_load = 1'b0;
        skid_pop  = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_tgt;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_tgt;
                    state_d   = rsp_vld ? S_REQ : S_DROP;
                end else if (rsp_vld) begin
                    pc_d = pc_plus4;
                    if (!buf_vld || !stall) begin
                        buf_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_SKID;
                    end
                end
            end
            S_SKID: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_tgt;
                    state_d   = S_REQ;
                end else if (!stall) begin
                    skid_pop = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_DROP: begin
                // The stale response still has to be absorbed before the new target goes out.
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_tgt;
                end
                if (rsp_vld) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_REQ && state_d == S_DROP) begin
                drop_addr_q <= pc_q;
            end
        end
    end

    if_fetch_buffer #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fetch_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (buf_clear),
        .load      (buf_load),
        .skid_load (skid_load),
        .skid_pop  (skid_pop),
        .consume   (consume),
        .in_dat    (rsp_entry),
        .out_dat   (buf_entry),
        .out_vld   (buf_vld)
    );

    assign bus.imem_req_o  = (state_q == S_REQ) || (state_q == S_DROP);
    assign bus.imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign bus.if_pc4_o    = buf_entry.pc4;
    assign bus.if_instr_o  = buf_entry.instr;
    assign bus.if_valid_o  = buf_vld;
    assign bus.if_flush_o  = ~buf_vld | redirect;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle vectors plus a delivery scoreboard.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(32)) ifc();

    if_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0020)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t sb_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: rvalid on the mem_lat-th cycle of a request (mem_lat=1 is same-cycle).
    assign ifc.imem_rvalid_i = ifc.imem_req_o && (mem_cnt == mem_lat - 1);
    assign ifc.imem_rdata_i  = mem_word(ifc.imem_addr_o);

    always @(posedge clk or negedge rst) begin
        if (!rst) mem_cnt <= 0;
        else if (ifc.imem_req_o && !ifc.imem_rvalid_i) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // IF/ID captures when the buffer is valid, not stalled and not flushed.
    always @(negedge clk) begin
        if (rst && ifc.if_valid_o && !ifc.stall_i && !ifc.redirect_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc4 %h expected no delivery", ifc.if_pc4_o);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc4", ifc.if_pc4_o, sb_e.pc4);
                chk("sb_instr", ifc.if_instr_o, sb_e.instr);
            end
        end
    end

    task automatic expect_pc4(input logic [31:0] pc4);
        exp_q.push_back('{pc4: pc4, instr: mem_word(pc4 - 32'd4)});
    endtask

    task automatic tick(input logic s, input logic r, input logic [31:0] rpc, input int lat);
        @(posedge clk);
        #1;
        ifc.stall_i       = s;
        ifc.redirect_i    = r;
        ifc.redirect_pc_i = rpc;
        mem_lat           = lat;
        @(negedge clk);
    endtask

    task automatic start_seq(input int lat, input logic s0);
        rst               = 1'b0;
        ifc.stall_i       = 1'b1;
        ifc.redirect_i    = 1'b0;
        ifc.redirect_pc_i = '0;
        mem_lat           = lat;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        ifc.stall_i = s0;
        @(negedge clk);
    endtask

    task automatic end_seq(input string name);
        tick(1'b1, 1'b0, 32'h0, mem_lat);
        chk({name, " drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_cyc(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc4);
        chk({tag, " req"}, 32'(ifc.imem_req_o), 32'(req));
        if (req) chk({tag, " addr"}, ifc.imem_addr_o, addr);
        chk({tag, " vld"}, 32'(ifc.if_valid_o), 32'(vld));
        if (vld) begin
            chk({tag, " pc4"}, ifc.if_pc4_o, pc4);
            chk({tag, " instr"}, ifc.if_instr_o, mem_word(pc4 - 32'd4));
        end
        chk({tag, " flush"}, 32'(ifc.if_flush_o), 32'(!vld || ifc.redirect_i));
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.stall_i       = 1'b1;
        ifc.redirect_i    = 1'b0;
        ifc.redirect_pc_i = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst vld", 32'(ifc.if_valid_o), 32'd0);
        chk("rst instr", ifc.if_instr_o, 32'h0000_0020);
        chk("rst pc4", ifc.if_pc4_o, 32'd0);
        chk("rst req", 32'(ifc.imem_req_o), 32'd0);

        // Zero-latency streaming, then stall into the skid.
        tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h4};
        tbl[3] = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h8};
        tbl[4] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'hC};
        tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h10};
        tbl[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10};
        tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10};
        start_seq(1, tbl[0].stall);
        expect_pc4(32'h4); expect_pc4(32'h8); expect_pc4(32'hC);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(tbl[i].stall, 1'b0, 32'h0, 1);
            chk_cyc($sformatf("t1 c%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc4);
            if (i < 2) chk($sformatf("t1 c%0d nop", i), ifc.if_instr_o, 32'h0000_0020);
        end
        end_seq("t1");

        // Three-cycle memory latency.
        start_seq(3, 1'b0);
        expect_pc4(32'h4); expect_pc4(32'h8);
        for (int c = 1; c <= 9; c++) begin
            tick(1'b0, 1'b0, 32'h0, 3);
            chk_cyc($sformatf("t2 c%0d", c), 1'b1, (c <= 3) ? 32'h0 : (c <= 6) ? 32'h4 : 32'h8,
                    (c == 4) || (c == 7), (c == 4) ? 32'h4 : 32'h8);
        end
        tick(1'b1, 1'b0, 32'h0, 3);
        chk_cyc("t2 c10", 1'b1, 32'hC, 1'b1, 32'hC);
        end_seq("t2");

        // Response arrives under stall: skid holds it, requests pause.
        start_seq(1, 1'b0);
        expect_pc4(32'h4); expect_pc4(32'h8); expect_pc4(32'hC);
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t3 c1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t3 c2", 1'b1, 32'h4, 1'b1, 32'h4);
        tick(1'b1, 1'b0, 32'h0, 1); chk_cyc("t3 c3", 1'b1, 32'h8, 1'b1, 32'h8);
        for (int c = 4; c <= 6; c++) begin
            tick(1'b1, 1'b0, 32'h0, 1);
            chk_cyc($sformatf("t3 c%0d", c), 1'b0, 32'h0, 1'b1, 32'h8);
        end
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t3 c7", 1'b0, 32'h0, 1'b1, 32'h8);
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t3 c8", 1'b1, 32'hC, 1'b1, 32'hC);
        tick(1'b1, 1'b0, 32'h0, 1); chk_cyc("t3 c9", 1'b1, 32'h10, 1'b1, 32'h10);
        end_seq("t3");

        // Redirect in the same cycle as a response.
        start_seq(1, 1'b0);
        expect_pc4(32'h4); expect_pc4(32'h8); expect_pc4(32'h44);
        tick(1'b0, 1'b0, 32'h0, 1);  chk_cyc("t4 c1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1);  chk_cyc("t4 c2", 1'b1, 32'h4, 1'b1, 32'h4);
        tick(1'b0, 1'b0, 32'h0, 1);  chk_cyc("t4 c3", 1'b1, 32'h8, 1'b1, 32'h8);
        tick(1'b0, 1'b1, 32'h40, 1); chk_cyc("t4 c4", 1'b1, 32'hC, 1'b1, 32'hC);
        tick(1'b0, 1'b0, 32'h0, 1);  chk_cyc("t4 c5", 1'b1, 32'h40, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1);  chk_cyc("t4 c6", 1'b1, 32'h44, 1'b1, 32'h44);
        tick(1'b1, 1'b0, 32'h0, 1);  chk_cyc("t4 c7", 1'b1, 32'h48, 1'b1, 32'h48);
        end_seq("t4");

        // Redirects while a slow request is outstanding.
        start_seq(1, 1'b0);
        expect_pc4(32'h4); expect_pc4(32'h8); expect_pc4(32'hC);
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 1'b0, 32'h0, 1);
            chk_cyc($sformatf("t5 c%0d", c), 1'b1, 32'(4 * (c - 1)), c > 1, 32'(4 * (c - 1)));
        end
        tick(1'b0, 1'b1, 32'h80, 3); chk_cyc("t5 c5", 1'b1, 32'h10, 1'b1, 32'h10);
        tick(1'b0, 1'b0, 32'h0, 3);  chk_cyc("t5 c6", 1'b1, 32'h10, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 3);  chk_cyc("t5 c7", 1'b1, 32'h10, 1'b0, 32'h0);
        for (int c = 8; c <= 10; c++) begin
            tick(1'b0, 1'b0, 32'h0, 3);
            chk_cyc($sformatf("t5 c%0d", c), 1'b1, 32'h80, 1'b0, 32'h0);
        end
        tick(1'b0, 1'b1, 32'h100, 3); chk_cyc("t5 c11", 1'b1, 32'h84, 1'b1, 32'h84);
        tick(1'b0, 1'b1, 32'hC3, 3);  chk_cyc("t5 c12", 1'b1, 32'h84, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 3);   chk_cyc("t5 c13", 1'b1, 32'h84, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 3);   chk_cyc("t5 c14", 1'b1, 32'hC0, 1'b0, 32'h0);
        end_seq("t5");

        // Reset pulsed while a request is outstanding.
        start_seq(1, 1'b0);
        expect_pc4(32'h4);
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t6 c1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1); chk_cyc("t6 c2", 1'b1, 32'h4, 1'b1, 32'h4);
        tick(1'b1, 1'b0, 32'h0, 3); chk_cyc("t6 c3", 1'b1, 32'h8, 1'b1, 32'h8);
        tick(1'b1, 1'b0, 32'h0, 3); chk_cyc("t6 c4", 1'b1, 32'h8, 1'b1, 32'h8);
        #2 rst = 1'b0;
        #1;
        chk("t6 arst vld", 32'(ifc.if_valid_o), 32'd0);
        chk("t6 arst instr", ifc.if_instr_o, 32'h0000_0020);
        chk("t6 arst pc4", ifc.if_pc4_o, 32'd0);
        chk("t6 arst req", 32'(ifc.imem_req_o), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        ifc.stall_i = 1'b0;
        @(negedge clk);
        chk_cyc("t6 boot", 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 3); chk_cyc("t6 c6", 1'b1, 32'h0, 1'b0, 32'h0);
        end_seq("t6");

        // PC wraps modulo 2^32.
        start_seq(1, 1'b0);
        expect_pc4(32'hFFFF_FFFC); expect_pc4(32'h0);
        tick(1'b0, 1'b0, 32'h0, 1);         chk_cyc("t7 c1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1); chk_cyc("t7 c2", 1'b1, 32'h4, 1'b1, 32'h4);
        tick(1'b0, 1'b0, 32'h0, 1);         chk_cyc("t7 c3", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1);         chk_cyc("t7 c4", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0, 1);         chk_cyc("t7 c5", 1'b1, 32'h0, 1'b1, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 1);         chk_cyc("t7 c6", 1'b1, 32'h4, 1'b1, 32'h4);
        end_seq("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the PC and issues one-outstanding requests to instruction memory over a req/rvalid handshake. Fetched {PC+4, instruction} pairs go into a one-entry output buffer plus a skid slot, and the unit produces the write data and flush request for IF/ID. Taken branches and jumps from ID arrive as redirects; the unit discards wrong-path fetches, including an in-flight memory response.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000020, bubble instruction (add $0,$0,$0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
stall_i  in  1  hazard-unit stall; same signal drives IF/ID stall_i
redirect_i  in  1  taken branch/jump resolved in ID
redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored (forced 00)
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address, word aligned
imem_rvalid_i  in  1  response valid; may assert in the same cycle as req
imem_rdata_i  in  32  instruction word
if_pc4_o  out  ADDR_W  PC+4 of buffered instruction (IF/ID write data)
if_instr_o  out  32  buffered instruction (IF/ID write data)
if_valid_o  out  1  buffer holds a valid correct-path instruction
if_flush_o  out  1  combinational: ~if_valid_o | redirect_i; drives IF/ID flush_i

Behaviour:
- Reset, asynchronous and active low, sets: pc_q=RESET_PC, state=BOOT, if_valid_o=0, if_pc4_o=0, if_instr_o=NOP_INSTR, skid invalid. Reset mid-request abandons the request; imem shares rst_i.
- Memory protocol: imem_req_o=1 only in REQ and DROP. Address is held stable until the first cycle with imem_rvalid_i=1. That cycle completes the transaction. imem_rvalid_i is ignored when req=0.
- States:
  - BOOT: req=0. Always -> REQ next cycle.
  - REQ: addr=pc_q.
  - SKID: req=0. Buffer full, skid full, stall active.
  - DROP: addr=stale address; response will be discarded.
- Buffer "consumed" this cycle = if_valid_o & ~stall_i. IF/ID captures the buffer on that edge.
- REQ with rvalid and no redirect:
  - If ~if_valid_o | ~stall_i: buffer <= {pc_q+4, rdata}, valid=1.
  - Else: skid <= {pc_q+4, rdata}, -> SKID.
  - Either way pc_q <= pc_q+4 and the next request issues the following cycle.
- REQ without rvalid: if consumed, valid <= 0.
- SKID with ~stall_i: buffer <= skid, skid invalid, -> REQ.
- Redirect has priority over stall and over any capture. In the same edge: valid <= 0, skid invalid, pc_q <= {redirect_pc_i[ADDR_W-1:2],2'b00}.
  - From REQ with rvalid: response discarded, stay REQ.
  - From REQ without rvalid: -> DROP.
  - From SKID or BOOT: -> REQ.
  - From DROP: stay DROP (target updated), or -> REQ if rvalid.
- DROP with rvalid and no redirect: response discarded, -> REQ at pc_q.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Throughput with zero-latency memory and no stalls: one instruction per cycle.
- Redirect-to-first-correct-path-valid latency: 2 cycles with zero-latency memory.
- Instructions are delivered in program order. No instruction is delivered twice; none is lost across stalls.

Decomposition:
- Package if_pkg holds:
  - state enum {BOOT, REQ, SKID, DROP}
  - NOP_INSTR
  - RESET_PC default
  - fetch entry struct {pc4[ADDR_W], instr[32]}
- One natural sub-module: if_fetch_buffer. It is the output entry plus the skid entry, with load/consume/clear controls, and owns if_valid_o.
- PC register and FSM stay in the top module.

Test Plan:
- Reset release, zero-latency memory returning addr-based words, no stalls:
  - imem_addr_o sequence 0,4,8 from cycle 1
  - if_pc4_o 4,8,12 on successive cycles
  - if_flush_o=0 after the first valid
- 3-cycle memory latency:
  - addr 0 held for 3 cycles
  - if_valid_o=1 for 1 cycle per 3
  - if_flush_o=1 in the gap cycles
- stall_i held 4 cycles while buffer valid (pc4=8) and rvalid arrives for addr 8:
  - skid captures pc4=12, req drops
  - after release, outputs pc4=8 then 12, then addr 12 requested
- redirect_i=1, target 32'h40, in the same cycle as rvalid for addr 12:
  - response dropped, if_valid_o=0 next cycle
  - next addr 32'h40; next delivered pc4=32'h44
- redirect_i to 32'h80 while a 3-cycle request to addr 16 is outstanding:
  - addr 16 held until rvalid, its data never appears
  - next request addr 32'h80
  - redirect again during DROP to 32'hC0: next request is 32'hC0
- rst_i pulsed low during an outstanding request:
  - outputs reset immediately (if_instr_o=32'h20, valid=0)
  - one BOOT cycle with req=0, then addr 0
